// File: rtl/shift_pkg.sv
// Shared definitions for the shift execute stage: op-codes, default width
// and a bit-reverse helper used to map left shifts onto the right-shift core.
package shift_pkg;

    localparam int SHIFT_DATA_WIDTH = 20;

    // Widest operand the bit-reverse helper supports.
    localparam int REV_MAX_W = 64;

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SLL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Reverses the low w bits of v; bits at w and above come back as zero.
    // The fixed-width full reversal keeps all indices constant, and the shift
    // realigns the reversed field down to bit 0.
    function automatic logic [REV_MAX_W-1:0] bit_reverse(input logic [REV_MAX_W-1:0] v,
                                                         input int w);
        logic [REV_MAX_W-1:0] r;
        for (int i = 0; i < REV_MAX_W; i++) begin
            r[i] = v[REV_MAX_W-1-i];
        end
        return r >> (REV_MAX_W - w);
    endfunction

endpackage

// File: rtl/shift_exec_shiftright.sv
// Combinational logical right shifter. A full-width amount at or above the
// operand width yields zero.
module shiftright
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = SHIFT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] amount_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    assign data_o = data_i >> amount_i;

endmodule

// File: rtl/shift_exec.sv
// Two-stage shift execute pipeline. Stage 1 holds the accepted operands and
// computes SRL/SRA/SLL through one right-shift core. Stage 2 holds the
// result for writeback. Full valid/ready backpressure, one request per cycle.
module shift_exec
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = SHIFT_DATA_WIDTH,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_amount,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_err
);

    // The width always fits in its own field because DATA_WIDTH < 2**DATA_WIDTH.
    localparam logic [DATA_WIDTH-1:0] WIDTH_AS_AMT = DATA_WIDTH'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES     = '1;

    function automatic logic [DATA_WIDTH-1:0] rev(input logic [DATA_WIDTH-1:0] v);
        return DATA_WIDTH'(bit_reverse({{(REV_MAX_W-DATA_WIDTH){1'b0}}, v}, DATA_WIDTH));
    endfunction

    // Stage 1 operand registers
    logic                  s1_valid_q, s1_valid_d;
    logic [1:0]            s1_op_q,    s1_op_d;
    logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [DATA_WIDTH-1:0] s1_amt_q,   s1_amt_d;
    logic [TAG_WIDTH-1:0]  s1_tag_q,   s1_tag_d;

    // Stage 2 result registers
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [TAG_WIDTH-1:0]  s2_tag_q,   s2_tag_d;
    logic                  s2_err_q,   s2_err_d;

    logic                  adv;
    logic                  accept;
    logic                  s1_msb;
    logic                  amt_sat;
    logic [DATA_WIDTH-1:0] core_in;
    logic [DATA_WIDTH-1:0] core_out;
    logic [DATA_WIDTH-1:0] sra_mask;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_err;

    // Handshake: stage 2 can take a new value when empty or draining;
    // stage 1 can take a new request when empty or moving into stage 2.
    always_comb begin
        adv      = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || adv;
        accept   = in_valid && in_ready;
    end

    // Core operand select: left shifts run through the core bit-reversed.
    always_comb begin
        s1_msb  = s1_data_q[DATA_WIDTH-1];
        amt_sat = (s1_amt_q >= WIDTH_AS_AMT);
        core_in = (s1_op_q == OP_SLL) ? rev(s1_data_q) : s1_data_q;
    end

    shiftright #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shiftright (
        .data_i  (core_in),
        .amount_i(s1_amt_q),
        .data_o  (core_out)
    );

    // Result shaping: saturation, arithmetic sign fill and un-reversal.
    always_comb begin
        res      = '0;
        res_err  = 1'b0;
        sra_mask = s1_msb ? ~(ALL_ONES >> s1_amt_q) : '0;
        case (s1_op_q)
            OP_SRL:  res = amt_sat ? '0 : core_out;
            OP_SRA:  res = amt_sat ? {DATA_WIDTH{s1_msb}} : (core_out | sra_mask);
            OP_SLL:  res = amt_sat ? '0 : rev(core_out);
            OP_RSVD: res_err = 1'b1;
        endcase
    end

    // Next-state for both stages; payloads only move with their valid.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;

        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res;
                s2_tag_d  = s1_tag_q;
                s2_err_d  = res_err;
            end
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_data_d  = in_data;
            s1_amt_d   = in_amount;
            s1_tag_d   = in_tag;
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_SRL;
            s1_data_q  <= '0;
            s1_amt_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s1_amt_q   <= s1_amt_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_shift_exec.sv
// Scoreboard bench for shift_exec: directed requests push hand-computed
// results; a monitor pops and compares on every output transfer.
module tb_shift_exec;
    import shift_pkg::*;

    localparam int W  = 20;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  in_amount = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;

    shift_exec #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .in_amount(in_amount),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted output against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got tag 0x%0h data 0x%0h expected no output", out_tag, out_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.d));
                    check("sb_tag",  32'(out_tag),  32'(e.t));
                    check("sb_err",  32'(out_err),  32'(e.e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one request; push its expected result when it is accepted.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [W-1:0] a,
                        input logic [TW-1:0] t, input logic [W-1:0] exp_d, input logic exp_e);
        bit   got;
        exp_t e;
        got       = 1'b0;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_amount = a;
        in_tag    = t;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for tag 0x%0h expected acceptance", t);
        end else begin
            e.d = exp_d;
            e.t = t;
            e.e = exp_e;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 20'h5A5A5;
        in_amount = 20'h00007;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_tag",   32'(out_tag),   32'h0);
        check("rst_out_err",   32'(out_err),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // First request with explicit latency check
        send(OP_SRL, 20'hAAAAA, 20'd3, 4'd1, 20'h15555, 1'b0);
        @(negedge clk);
        check("lat_not_early", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'h1);
        check("lat_data",  32'(out_data),  32'h15555);
        idle(1);

        // Back-to-back directed vectors
        send(OP_SRA,  20'h8A8AA, 20'd7,      4'd2,  20'hFF151, 1'b0);
        send(OP_SRA,  20'h80000, 20'd25,     4'd3,  20'hFFFFF, 1'b0);
        send(OP_SRL,  20'h80000, 20'd25,     4'd4,  20'h00000, 1'b0);
        send(OP_SLL,  20'h00001, 20'd19,     4'd5,  20'h80000, 1'b0);
        send(OP_SLL,  20'h00001, 20'd20,     4'd6,  20'h00000, 1'b0);
        send(OP_SLL,  20'h00001, 20'd0,      4'd7,  20'h00001, 1'b0);
        send(OP_SRL,  20'h12345, 20'd32,     4'd8,  20'h00000, 1'b0);
        send(OP_SRA,  20'h92345, 20'h10003,  4'd9,  20'hFFFFF, 1'b0);
        send(OP_SRA,  20'h92345, 20'd0,      4'd10, 20'h92345, 1'b0);
        send(OP_SLL,  20'h00003, 20'd4,      4'd11, 20'h00030, 1'b0);
        send(OP_RSVD, 20'h12345, 20'd2,      4'd7,  20'h00000, 1'b1);
        send(OP_SRL,  20'h00100, 20'd8,      4'd12, 20'h00001, 1'b0);
        idle(4);

        // Backpressure: two accepted, third waits, then drain in order
        out_ready = 1'b0;
        fork
            begin
                send(OP_SRL, 20'h0000F, 20'd1, 4'd1, 20'h00007, 1'b0);
                send(OP_SLL, 20'h00003, 20'd4, 4'd2, 20'h00030, 1'b0);
                send(OP_SRA, 20'hF0000, 20'd4, 4'd3, 20'hFF000, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", 32'(in_ready), 32'h0);
                check("bp_hold_valid",   32'(out_valid), 32'h1);
                check("bp_hold_tag",     32'(out_tag),   32'h1);
                check("bp_hold_data",    32'(out_data),  32'h00007);
                @(negedge clk);
                check("bp_still_blocked", 32'(in_ready), 32'h0);
                check("bp_stable_data",   32'(out_data), 32'h00007);
                check("bp_stable_err",    32'(out_err),  32'h0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    check("bp_seq_valid", 32'(out_valid), 32'h1);
                    check("bp_seq_tag",   32'(out_tag),   32'(k));
                end
            end
        join
        idle(4);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(OP_SRL, 20'h12345, 20'd0, 4'd5, 20'h12345, 1'b0);
        send(OP_SRL, 20'h0F0F0, 20'd4, 4'd6, 20'h00F0F, 1'b0);
        #2;
        check("arst_pre_valid", 32'(out_valid), 32'h1);
        check("arst_pre_full",  32'(in_ready),  32'h0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_data",  32'(out_data),  32'h0);
        check("arst_out_tag",   32'(out_tag),   32'h0);
        check("arst_out_err",   32'(out_err),   32'h0);
        sb.delete();
        #10;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("arst_post_ready", 32'(in_ready),  32'h1);
        check("arst_post_empty", 32'(out_valid), 32'h0);
        idle(2);
        check("arst_no_stale", 32'(out_valid), 32'h0);

        // Pipe works again after reset
        send(OP_SRL, 20'h00F00, 20'd8, 4'd9, 20'h0000F, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
